// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// It decodes the opcode and steps each instruction through fetch, decode,
// execute, memory and writeback. It also keeps a retired-instruction counter
// and a sticky illegal-opcode flag.
// The control outputs are a Moore decode of the state register. They are
// gated by reset_n, so they read 0 while reset is held and show the FETCH
// controls as soon as reset is released.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             illegal_q, illegal_d;

    logic [1:0] alu_op_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       mem_to_reg_s;
    logic [1:0] pc_source_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;

    // Next-state, retire-counter and illegal-flag logic
    always_comb begin
        state_d       = S_FETCH;
        instr_count_d = instr_count_q;
        illegal_d     = illegal_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        // Unsupported opcode: back to FETCH without retiring
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_MEM_READ: state_d = S_MEM_WB;
            S_EXECUTE:  state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                // Last state of a legal instruction: it retires here
                state_d       = S_FETCH;
                instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // State, retire counter and sticky illegal flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= {CNT_W{1'b0}};
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            illegal_q     <= illegal_d;
        end
    end

    // Moore decode of the per-state control signals
    always_comb begin
        alu_op_s        = 2'b00;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        mem_to_reg_s    = 1'b0;
        pc_source_s     = 2'b00;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                ir_write_s  = 1'b1;
                alu_src_b_s = 2'b01;
                pc_write_s  = 1'b1;
            end
            S_DECODE:    alu_src_b_s = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            S_ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDI_WB:   reg_write_s = 1'b1;
            default:     alu_op_s = 2'b00;
        endcase
    end

    // Force every control output low while reset is held
    assign alu_op      = reset_n ? alu_op_s     : 2'b00;
    assign alu_src_a   = reset_n & alu_src_a_s;
    assign alu_src_b   = reset_n ? alu_src_b_s  : 2'b00;
    assign iord        = reset_n & iord_s;
    assign mem_read    = reset_n & mem_read_s;
    assign mem_write   = reset_n & mem_write_s;
    assign ir_write    = reset_n & ir_write_s;
    assign reg_dst     = reset_n & reg_dst_s;
    assign reg_write   = reset_n & reg_write_s;
    assign mem_to_reg  = reset_n & mem_to_reg_s;
    assign pc_source   = reset_n ? pc_source_s  : 2'b00;
    assign pc_en       = reset_n & (pc_write_s | (pc_write_cond_s & zero));
    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control.
// Expected values are hand-derived from the state table.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        zero;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  pc_source;
    logic        pc_en;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        illegal_op;

    int n_vec = 0;
    int n_err = 0;

    mips_multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .pc_en(pc_en),
        .state(state), .instr_count(instr_count), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pack the control outputs as {alu_op,src_a,src_b,iord,mr,mw,irw,rdst,rw,m2r,pcsrc,pc_en}
    function automatic logic [31:0] ctl();
        return {17'd0, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                ir_write, reg_dst, reg_write, mem_to_reg, pc_source, pc_en};
    endfunction

    // Build the expected control word in the same field order as ctl()
    function automatic logic [31:0] exp_ctl(input logic [1:0] aop, input logic sa,
            input logic [1:0] sb, input logic io, input logic mr, input logic mw,
            input logic irw, input logic rd, input logic rw, input logic m2r,
            input logic [1:0] ps, input logic pe);
        return {17'd0, aop, sa, sb, io, mr, mw, irw, rd, rw, m2r, ps, pe};
    endfunction

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        opcode  = 6'b100011;
        zero    = 1'b0;
        #3;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_ill", {31'd0, illegal_op}, 32'd0);
        tick();
        tick();
        chk("rst_hold_ctl", ctl(), 32'd0);

        // Release reset: FETCH controls appear immediately
        reset_n = 1'b1;
        #1;
        chk("lw_s0", {28'd0, state}, 32'd0);
        chk("lw_fetch_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1));
        tick();
        chk("lw_s1", {28'd0, state}, 32'd1);
        chk("lw_dec_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("lw_s2", {28'd0, state}, 32'd2);
        chk("lw_addr_ctl", ctl(), exp_ctl(2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("lw_s3", {28'd0, state}, 32'd3);
        chk("lw_rd_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("lw_s4", {28'd0, state}, 32'd4);
        chk("lw_wb_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0));
        chk("lw_cnt_before", instr_count, 32'd0);
        tick();
        chk("lw_back_s0", {28'd0, state}, 32'd0);
        chk("lw_cnt", instr_count, 32'd1);

        // R-type then sw
        opcode = 6'b000000;
        tick();
        tick();
        chk("r_s6", {28'd0, state}, 32'd6);
        chk("r_ex_ctl", ctl(), exp_ctl(2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("r_s7", {28'd0, state}, 32'd7);
        chk("r_wb_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0));
        tick();
        chk("r_cnt", instr_count, 32'd2);
        opcode = 6'b101011;
        tick();
        tick();
        chk("sw_s2", {28'd0, state}, 32'd2);
        chk("sw_s2_mw", {31'd0, mem_write}, 32'd0);
        tick();
        chk("sw_s5", {28'd0, state}, 32'd5);
        chk("sw_wr_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("sw_s0", {28'd0, state}, 32'd0);
        chk("sw_cnt", instr_count, 32'd3);

        // beq with zero=1 (taken)
        opcode = 6'b000100;
        zero   = 1'b1;
        tick();
        chk("beq_dec_pcen", {31'd0, pc_en}, 32'd0);
        tick();
        chk("beq1_s8", {28'd0, state}, 32'd8);
        chk("beq1_ctl", ctl(), exp_ctl(2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1));
        zero = 1'b0;
        #1;
        chk("beq1_pcen_comb", {31'd0, pc_en}, 32'd0);
        zero = 1'b1;
        tick();
        chk("beq1_s0", {28'd0, state}, 32'd0);
        chk("beq1_cnt", instr_count, 32'd4);

        // beq with zero=0 (not taken)
        zero = 1'b0;
        tick();
        tick();
        chk("beq0_s8", {28'd0, state}, 32'd8);
        chk("beq0_pcen", {31'd0, pc_en}, 32'd0);
        tick();
        chk("beq0_s0", {28'd0, state}, 32'd0);
        chk("beq0_cnt", instr_count, 32'd5);

        // j then addi
        opcode = 6'b000010;
        tick();
        tick();
        chk("j_s9", {28'd0, state}, 32'd9);
        chk("j_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1));
        tick();
        chk("j_cnt", instr_count, 32'd6);
        opcode = 6'b001000;
        tick();
        tick();
        chk("addi_s10", {28'd0, state}, 32'd10);
        chk("addi_ex_ctl", ctl(), exp_ctl(2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0));
        tick();
        chk("addi_s11", {28'd0, state}, 32'd11);
        chk("addi_wb_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0));
        tick();
        chk("addi_s0", {28'd0, state}, 32'd0);
        chk("addi_cnt", instr_count, 32'd7);

        // Illegal opcode: 2 cycles, no retire, sticky flag
        opcode = 6'b111111;
        tick();
        chk("ill_dec_flag", {31'd0, illegal_op}, 32'd0);
        tick();
        chk("ill_s0", {28'd0, state}, 32'd0);
        chk("ill_flag", {31'd0, illegal_op}, 32'd1);
        chk("ill_cnt", instr_count, 32'd7);
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) tick();
        chk("ill_lw_s0", {28'd0, state}, 32'd0);
        chk("ill_lw_cnt", instr_count, 32'd8);
        chk("ill_sticky", {31'd0, illegal_op}, 32'd1);

        // Mid-instruction reset in MEM_READ
        tick();
        tick();
        tick();
        chk("mr_s3", {28'd0, state}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_rst_state", {28'd0, state}, 32'd0);
        chk("mr_rst_ctl", ctl(), 32'd0);
        chk("mr_rst_cnt", instr_count, 32'd0);
        chk("mr_rst_ill", {31'd0, illegal_op}, 32'd0);
        tick();
        chk("mr_hold_ctl", ctl(), 32'd0);
        chk("mr_hold_state", {28'd0, state}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("mr_rel_ctl", ctl(), exp_ctl(2'b00,1'b0,2'b01,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1));
        tick();
        chk("mr_rel_s1", {28'd0, state}, 32'd1);
        tick();
        chk("mr_rel_s2", {28'd0, state}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
